// File: rtl/effect_distortion_multi.sv
// Multi-mode distortion: hard clip, stepped quantiser, asymmetric clip.
// Three-stage pipeline with a slew-limited ceiling and a clip counter.
module effect_distortion_multi #(
  parameter int DATA_W    = 16,
  parameter int N_STEPS   = 12,
  parameter int RAMP_STEP = 256,
  parameter int CNT_W     = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic                     i_enable,
  input  logic [1:0]               i_mode,
  input  logic [2:0]               i_level,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_clr_cnt,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_clip,
  output logic [CNT_W-1:0]         o_clip_cnt
);

  typedef enum logic [1:0] {
    M_BYP  = 2'd0,
    M_HARD = 2'd1,
    M_STEP = 2'd2,
    M_ASYM = 2'd3
  } mode_e;

  typedef struct packed {
    logic              valid;
    logic              en;
    mode_e             mode;
    logic              neg;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] cmax;
  } s1_t;

  typedef struct packed {
    logic              valid;
    logic              neg;
    logic [DATA_W-1:0] mag;
    logic              clip;
  } s2_t;

  localparam logic signed [DATA_W-1:0] MIN_NEG =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MIN_SAFE =
    {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] RST_MAX =
    DATA_W'(7) << (DATA_W-4);
  localparam logic [DATA_W-1:0] RSTEP = DATA_W'(RAMP_STEP);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [DATA_W-1:0] cur_max_q, cur_max_d;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  logic signed [DATA_W-1:0] o_data_q, o_data_d;
  logic              o_valid_q, o_valid_d;
  logic              o_clip_q, o_clip_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]        lvl;
  logic [DATA_W-1:0] tgt;
  logic signed [DATA_W-1:0] sat;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] stp;
  logic [DATA_W-1:0] thr;
  logic [DATA_W-1:0] lim;
  logic              hit;
  logic              byp;

  // Ceiling slews toward the level target, only on accepted samples.
  always_comb begin
    lvl       = (i_level == 3'd0) ? 3'd7 : i_level;
    tgt       = DATA_W'(lvl) << (DATA_W-4);
    cur_max_d = cur_max_q;
    if (i_valid) begin
      if (tgt > cur_max_q) begin
        cur_max_d = (tgt - cur_max_q > RSTEP)
                  ? cur_max_q + RSTEP : tgt;
      end else if (cur_max_q > tgt) begin
        cur_max_d = (cur_max_q - tgt > RSTEP)
                  ? cur_max_q - RSTEP : tgt;
      end
    end
  end

  always_comb begin
    sat        = (i_data == MIN_NEG) ? MIN_SAFE : i_data;
    s1_d       = '0;
    s1_d.valid = i_valid;
    s1_d.en    = i_enable;
    s1_d.mode  = mode_e'(i_mode);
    s1_d.neg   = sat[DATA_W-1];
    s1_d.mag   = sat[DATA_W-1] ? (~sat + 1'b1) : sat;
    s1_d.cmax  = cur_max_q;
  end

  // Stepped mode: first threshold from the top the sample reaches.
  always_comb begin
    res = s1_q.mag;
    stp = s1_q.cmax >> 4;
    thr = s1_q.cmax;
    hit = 1'b0;
    lim = s1_q.neg ? (s1_q.cmax >> 1) : s1_q.cmax;
    case (s1_q.mode)
      M_HARD: begin
        if (s1_q.mag > s1_q.cmax) res = s1_q.cmax;
      end
      M_STEP: begin
        for (int k = 0; k < N_STEPS; k++) begin
          if (!hit && s1_q.mag >= thr) begin
            res = thr;
            hit = 1'b1;
          end
          thr = thr - stp;
        end
      end
      M_ASYM: begin
        if (s1_q.mag > lim) res = lim;
      end
      default: res = s1_q.mag;
    endcase
    byp = !s1_q.en || (s1_q.mode == M_BYP);
    if (byp) res = s1_q.mag;
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.neg   = s1_q.neg;
    s2_d.mag   = res;
    s2_d.clip  = s1_q.valid && !byp && (res != s1_q.mag);
  end

  always_comb begin
    o_data_d  = o_data_q;
    if (s2_q.valid) begin
      o_data_d = s2_q.neg ? (~s2_q.mag + 1'b1) : s2_q.mag;
    end
    o_valid_d = s2_q.valid;
    o_clip_d  = s2_q.valid && s2_q.clip;
    cnt_d     = cnt_q;
    if (i_clr_cnt) begin
      cnt_d = '0;
    end else if (o_clip_d && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cur_max_q <= RST_MAX;
      s1_q      <= '0;
      s2_q      <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_clip_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cur_max_q <= cur_max_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      o_clip_q  <= o_clip_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_data     = o_data_q;
  assign o_valid    = o_valid_q;
  assign o_clip     = o_clip_q;
  assign o_clip_cnt = cnt_q;

endmodule

// File: doc/effect_distortion_multi.md
EFFECT_DISTORTION_MULTI -- requirements
Module: effect_distortion_multi

Interface
REQ-001 Parameter DATA_W, 16, sample width (signed, two's complement, >= 8).
REQ-002 Parameter N_STEPS, 12, number of quantisation thresholds in stepped mode (1..16).
REQ-003 Parameter RAMP_STEP, 256, maximum change of the working ceiling per valid sample.
REQ-004 Parameter CNT_W, 16, width of the clip counter.
REQ-005 One clock; reset is synchronous and active-low: i_clk, i_rst_n.
REQ-006 i_clk  in  1  clock.
REQ-007 i_rst_n  in  1  synchronous active-low reset.
REQ-008 i_valid  in  1  input sample strobe.
REQ-009 i_enable  in  1  effect on; 0 = bypass.
REQ-010 i_mode  in  2  0 = bypass, 1 = hard clip, 2 = stepped, 3 = asymmetric clip.
REQ-011 i_level  in  3  ceiling level; 0 is treated as 7.
REQ-012 i_data  in  DATA_W  signed input sample.
REQ-013 i_clr_cnt  in  1  clear the clip counter.
REQ-014 o_data  out  DATA_W  signed processed sample.
REQ-015 o_valid  out  1  output sample strobe.
REQ-016 o_clip  out  1  one-cycle pulse with o_valid when the output magnitude differs from the input magnitude.
REQ-017 o_clip_cnt  out  CNT_W  saturating count of clipped output samples.

Function
REQ-018 Target ceiling SHALL be level << (DATA_W-4), with level = (i_level==0) ? 7 : i_level.
REQ-019 The working ceiling register cur_max SHALL move toward the target on each cycle with i_valid=1, by min(RAMP_STEP, |target-cur_max|); it SHALL hold when i_valid=0.
REQ-020 Step size SHALL be cur_max >>> 4; threshold t_k = cur_max - k*step for k = 0..N_STEPS-1, using the cur_max value captured with the sample.
REQ-021 Stage 1 SHALL register the sample (most-negative value replaced by most-negative+1), its sign, its magnitude, cur_max, i_enable, i_mode and i_valid.
REQ-022 Stage 2 SHALL compute the result magnitude: hard clip = min(abs, cur_max); stepped = t_k for the smallest k with abs >= t_k, else abs; asymmetric = min(abs, cur_max) if positive, min(abs, cur_max>>>1) if negative.
REQ-023 Stage 3 SHALL restore the sign and register o_data, o_valid and o_clip.
REQ-024 Latency from i_valid to o_valid SHALL be exactly 3 cycles; the pipeline SHALL advance every cycle with no stall; o_valid SHALL repeat the i_valid pattern.
REQ-025 With enable=0 or mode=0, o_data SHALL equal the stage-1 sample (after the most-negative substitution) and o_clip SHALL be 0.
REQ-026 Enable and mode SHALL be sampled per sample in stage 1; a change mid-stream SHALL affect only samples entering after the change.
REQ-027 o_data SHALL update only when the stage-2 valid is 1; it holds otherwise.
REQ-028 o_clip_cnt SHALL increment on each o_clip pulse and saturate at 2^CNT_W-1.
REQ-029 If i_clr_cnt and an o_clip pulse occur in the same cycle, clear SHALL win and the count SHALL be 0.
REQ-030 All arithmetic SHALL be at DATA_W width with no overflow; magnitudes never exceed 2^(DATA_W-1)-1.

Reset
REQ-031 With i_rst_n=0 at a clock edge: o_data=0, o_valid=0, o_clip=0, o_clip_cnt=0, all pipeline registers cleared, and cur_max = 7 << (DATA_W-4).
REQ-032 Reset mid-stream SHALL discard in-flight samples; no o_valid is produced for them.

Verification (defaults, DATA_W=16, so the level-7 ceiling is 28672 and the step is 1792)
REQ-033 Stepped mode, level 7, input 20000 -> o_data 19712 three cycles later with o_clip=1; input -20000 -> -19712.
REQ-034 Stepped mode, input 5000 (below t11=8960) -> o_data 5000, o_clip=0.
REQ-035 Hard clip mode, input 30000 -> 28672; input 0x8000 -> -28672; o_clip_cnt increments by 2.
REQ-036 Asymmetric mode, level 7, input -20000 -> -14336; input 20000 -> 20000.
REQ-037 Level change 7 to 1 with continuous valid -> cur_max falls 256 per sample and reaches 4096 after 96 samples; the hard-clip output tracks this.
REQ-038 With CNT_W=4, 20 consecutive clipping samples -> o_clip_cnt=15; i_clr_cnt asserted together with a clip -> 0; reset mid-stream -> o_valid=0 on the next cycle.
